sample_queue_scheduler: RTL and testbench

SAMPLE_QUEUE_SCHEDULER -- requirements
Module: sample_queue_scheduler

---
 rtl/spc_audio_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 38 +++
 rtl/sample_queue_scheduler.sv | 136 +++++++++++++
 tb/tb_sample_queue_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spc_audio_pkg.sv
// Shared definitions for the audio sample path: sample width, scheduler states
// and the saturating underrun counter helper.
package spc_audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int URUN_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DEQ     = 2'd1,
        ST_CAPTURE = 2'd2
    } sched_state_e;

    function automatic logic [URUN_CNT_W-1:0] sat_inc(input logic [URUN_CNT_W-1:0] value);
        logic [URUN_CNT_W-1:0] result;
        if (value == {URUN_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(URUN_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered preference
// that hands priority to the other requester after each grant.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic       prefer_aux_r;
    logic [1:0] grant_s;

    // Single requester wins outright; a tie goes to the preferred side
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = prefer_aux_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // Preference flips to the loser only when a grant was actually issued
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prefer_aux_r <= 1'b0;
        end else if (advance && (grant_s != 2'b00)) begin
            prefer_aux_r <= grant_s[0];
        end else begin
            prefer_aux_r <= prefer_aux_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/sample_queue_scheduler.sv
// Merges two sample producers into one queue and drains it to the DAC at a
// fixed sample rate, flagging and counting periods that find the queue empty.
module sample_queue_scheduler
    import spc_audio_pkg::*;
#(
    parameter int QUEUE_SIZE = 16,
    parameter int SIZE_W     = $clog2(QUEUE_SIZE),
    parameter int RATE_DIV   = 768
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  dsp_valid,
    input  logic [SAMPLE_W-1:0]   dsp_sample,
    output logic                  dsp_ready,
    input  logic                  aux_valid,
    input  logic [SAMPLE_W-1:0]   aux_sample,
    output logic                  aux_ready,
    output logic                  q_enqueue,
    output logic [SAMPLE_W-1:0]   q_sample,
    output logic                  q_dequeue,
    input  logic [SIZE_W-1:0]     q_size,
    input  logic [SAMPLE_W-1:0]   q_data,
    output logic [SAMPLE_W-1:0]   dac_sample,
    output logic                  dac_strobe,
    output logic                  underrun,
    output logic [URUN_CNT_W-1:0] underrun_count
);

    localparam int              CNT_W    = $clog2(RATE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);

    sched_state_e          state_r;
    sched_state_e          state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic                  tick_s;
    logic                  q_full_s;
    logic                  q_empty_s;
    logic                  window_s;
    logic                  urun_evt_s;
    logic [1:0]            req_s;
    logic [1:0]            grant_s;
    logic [SAMPLE_W-1:0]   dac_hold_r;
    logic                  dac_strobe_r;
    logic                  underrun_r;
    logic [URUN_CNT_W-1:0] urun_cnt_r;

    assign tick_s     = enable && (cnt_r == CNT_LAST);
    assign q_full_s   = &q_size;
    assign q_empty_s  = (q_size == {SIZE_W{1'b0}});
    assign urun_evt_s = (state_r == ST_IDLE) && tick_s && q_empty_s;
    // reset_n gates the window so readies drop the instant reset asserts
    assign window_s   = reset_n && (state_r != ST_DEQ) && !tick_s && !q_full_s;
    assign req_s      = window_s ? {aux_valid, dsp_valid} : 2'b00;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req_s),
        .advance (window_s),
        .grant   (grant_s)
    );

    // Sample-period counter; tick marks the last cycle of each period
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!enable || tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Next-state logic for the dequeue sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s && !q_empty_s) begin
                    state_nxt_s = ST_DEQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DEQ:     state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Strobe lands on the CAPTURE cycle, or one cycle after an empty tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dac_strobe_r <= 1'b0;
            underrun_r   <= 1'b0;
            urun_cnt_r   <= {URUN_CNT_W{1'b0}};
            dac_hold_r   <= {SAMPLE_W{1'b0}};
        end else begin
            dac_strobe_r <= (state_r == ST_DEQ) || urun_evt_s;
            underrun_r   <= urun_evt_s;
            if (urun_evt_s) begin
                urun_cnt_r <= sat_inc(urun_cnt_r);
            end else begin
                urun_cnt_r <= urun_cnt_r;
            end
            if (state_r == ST_CAPTURE) begin
                dac_hold_r <= q_data;
            end else begin
                dac_hold_r <= dac_hold_r;
            end
        end
    end

    // The queue's registered output is forwarded during CAPTURE so the new
    // sample is visible in the same cycle as its strobe.
    assign dac_sample     = (state_r == ST_CAPTURE) ? q_data : dac_hold_r;
    assign dac_strobe     = dac_strobe_r;
    assign underrun       = underrun_r;
    assign underrun_count = urun_cnt_r;
    assign q_dequeue      = (state_r == ST_DEQ);
    assign dsp_ready      = grant_s[0];
    assign aux_ready      = grant_s[1];
    assign q_enqueue      = grant_s[0] | grant_s[1];
    assign q_sample       = grant_s[1] ? aux_sample : dsp_sample;

endmodule

// File: tb/tb_sample_queue_scheduler.sv
// Self-checking bench: a behavioural queue plus a period/transaction-level
// reference model predicting every scheduler output cycle by cycle.
module tb_sample_queue_scheduler;

    localparam int RD = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        dsp_valid, aux_valid;
    logic [15:0] dsp_sample, aux_sample;
    logic        dsp_ready, aux_ready;
    logic        q_enqueue, q_dequeue;
    logic [15:0] q_sample;
    logic [3:0]  q_size;
    logic [15:0] q_data;
    logic [15:0] dac_sample;
    logic        dac_strobe, underrun;
    logic [7:0]  underrun_count;

    always #5 clock = ~clock;

    sample_queue_scheduler #(.QUEUE_SIZE(16), .SIZE_W(4), .RATE_DIV(RD)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .dsp_valid(dsp_valid), .dsp_sample(dsp_sample), .dsp_ready(dsp_ready),
        .aux_valid(aux_valid), .aux_sample(aux_sample), .aux_ready(aux_ready),
        .q_enqueue(q_enqueue), .q_sample(q_sample), .q_dequeue(q_dequeue),
        .q_size(q_size), .q_data(q_data), .dac_sample(dac_sample),
        .dac_strobe(dac_strobe), .underrun(underrun), .underrun_count(underrun_count)
    );

    // Attached queue: registered output, occupancy updated each edge
    logic [15:0] env_q[$];
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            env_q.delete();
            q_data <= 16'h0;
            q_size <= 4'd0;
        end else begin
            if (q_dequeue && env_q.size() > 0) q_data <= env_q.pop_front();
            if (q_enqueue) env_q.push_back(q_sample);
            q_size <= 4'(env_q.size());
        end
    end

    int total = 0;
    int bad = 0;

    logic        stg_rst = 1'b0, stg_en = 1'b0, stg_dv = 1'b0, stg_av = 1'b0;
    logic [15:0] stg_ds = 16'h0, stg_as = 16'h0;

    int          cyc, now_cyc, run_len, deq_cyc, cap_cyc, urun_cyc, ucnt;
    logic [15:0] mq[$];
    logic [15:0] held, cap_val;
    bit          pref_aux;
    logic [45:0] exp_vec;

    function automatic logic [45:0] obs();
        logic [15:0] qs;
        qs = q_enqueue ? q_sample : 16'h0;
        return {dsp_ready, aux_ready, q_enqueue, q_dequeue, dac_strobe, underrun,
                qs, dac_sample, underrun_count};
    endfunction

    task automatic model_reset();
        cyc = 0; run_len = 0; deq_cyc = -10; cap_cyc = -10; urun_cyc = -10;
        ucnt = 0; mq.delete(); held = 16'h0; cap_val = 16'h0; pref_aux = 1'b0;
    endtask

    // One clock: apply staged inputs at the falling edge, then predict this cycle
    task automatic step();
        int          occ;
        bit          tk, in_deq, in_cap, in_urun, gd, ga;
        logic [15:0] smp, dac;
        @(negedge clock);
        reset_n = stg_rst; enable = stg_en; dsp_valid = stg_dv; aux_valid = stg_av;
        dsp_sample = stg_ds; aux_sample = stg_as;
        #1;
        if (!reset_n) begin
            model_reset();
            now_cyc = -1;
            exp_vec = 46'h0;
        end else begin
            now_cyc = cyc;
            occ     = mq.size();
            tk      = enable && ((run_len % RD) == RD - 1);
            in_deq  = (cyc == deq_cyc);
            in_cap  = (cyc == cap_cyc);
            in_urun = (cyc == urun_cyc);
            gd = 1'b0; ga = 1'b0;
            if (!tk && !in_deq && occ < 15) begin
                if (dsp_valid && aux_valid) begin
                    if (pref_aux) ga = 1'b1; else gd = 1'b1;
                end else if (dsp_valid) gd = 1'b1;
                else if (aux_valid) ga = 1'b1;
            end
            smp = ga ? aux_sample : dsp_sample;
            dac = in_cap ? cap_val : held;
            exp_vec = {gd, ga, gd | ga, in_deq, in_cap | in_urun, in_urun,
                       (gd | ga) ? smp : 16'h0, dac, 8'(ucnt)};
            if (gd | ga) begin pref_aux = gd; mq.push_back(smp); end
            if (in_cap) held = cap_val;
            if (in_deq) cap_val = mq.pop_front();
            if (tk) begin
                if (occ > 0) begin deq_cyc = cyc + 1; cap_cyc = cyc + 2; end
                else begin urun_cyc = cyc + 1; if (ucnt < 255) ucnt++; end
            end
            run_len = enable ? run_len + 1 : 0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        stg_rst = 1'b0; stg_en = 1'b1; stg_dv = 1'b1; stg_av = 1'b1;
        stg_ds = 16'($urandom); stg_as = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL reset_state got=%h want=%h", obs(), exp_vec); end
            total++;
            if ({dsp_ready, aux_ready, q_enqueue} !== 3'b000) begin
                bad++; $display("FAIL reset_ready got=%b want=000", {dsp_ready, aux_ready, q_enqueue});
            end
        end
    endtask

    task automatic test_underrun();
        int seen = 0;
        stg_rst = 1'b1; stg_en = 1'b1; stg_dv = 1'b0; stg_av = 1'b0;
        for (int i = 0; i < 3 * RD + 1; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL underrun_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
            if (underrun) begin
                seen++;
                total++;
                if (underrun_count !== 8'(seen)) begin bad++; $display("FAIL underrun_count got=%0d want=%0d", underrun_count, seen); end
            end
        end
        total++;
        if (seen != 3 || dac_sample !== 16'h0) begin
            bad++; $display("FAIL underrun_total got=%0d/%h want=3/0000", seen, dac_sample);
        end
    endtask

    task automatic test_single_push();
        int enq = 0, push_c, tickc, deq_c = -1, strobe_c = -1;
        logic [15:0] strobe_val = 16'h0;
        stg_rst = 1'b0; stg_dv = 1'b0; stg_av = 1'b0; stg_en = 1'b1;
        step();
        stg_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin stg_dv = 1'b1; stg_ds = 16'h1234; end
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL push_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
            if (q_enqueue) enq++;
        end
        push_c = now_cyc;
        stg_dv = 1'b0;
        tickc = push_c + (RD - 1) - (push_c % RD);
        for (int i = 0; i < 2 * RD; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL push_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
            if (q_enqueue) enq++;
            if (q_dequeue && deq_c < 0) deq_c = now_cyc;
            if (dac_strobe && strobe_c < 0) begin strobe_c = now_cyc; strobe_val = dac_sample; end
        end
        total++;
        if (enq != 1) begin bad++; $display("FAIL push_enqueues got=%0d want=1", enq); end
        total++;
        if (deq_c != tickc + 1) begin bad++; $display("FAIL push_deq_latency got=%0d want=%0d", deq_c, tickc + 1); end
        total++;
        if (strobe_c != tickc + 2 || strobe_val !== 16'h1234) begin
            bad++; $display("FAIL push_strobe got=%0d/%h want=%0d/1234", strobe_c, strobe_val, tickc + 2);
        end
    endtask

    task automatic test_round_robin();
        int first = -1, last = -1, g;
        stg_rst = 1'b0; stg_en = 1'b1;
        step();
        stg_rst = 1'b1; stg_dv = 1'b1; stg_av = 1'b1;
        for (int i = 0; i < 2 * RD; i++) begin
            stg_ds = 16'($urandom); stg_as = 16'($urandom);
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL rr_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
            total++;
            if (dsp_ready && aux_ready) begin bad++; $display("FAIL rr_both_ready got=11 want=not both"); end
            if (q_enqueue) begin
                g = aux_ready ? 1 : 0;
                if (first < 0) first = g;
                else begin
                    total++;
                    if (g == last) begin bad++; $display("FAIL rr_alternate cyc=%0d got=%0d want=%0d", now_cyc, g, 1 - last); end
                end
                last = g;
            end
        end
        total++;
        if (first != 0) begin bad++; $display("FAIL rr_first got=%0d want=0", first); end
    endtask

    task automatic test_full();
        int full_seen = 0;
        stg_dv = 1'b1; stg_av = 1'b0;
        for (int i = 0; i < 4 * RD; i++) begin
            stg_ds = 16'($urandom);
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL full_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
            if (q_size == 4'hF) begin
                full_seen++;
                total++;
                if (dsp_ready || q_enqueue) begin bad++; $display("FAIL full_block got=%b%b want=00", dsp_ready, q_enqueue); end
            end
        end
        total++;
        if (full_seen == 0) begin bad++; $display("FAIL full_reached got=0 want=>0"); end
    endtask

    task automatic test_enable_drop();
        int tickc, strobe_c = -1;
        logic [15:0] v, sv = 16'h0;
        stg_rst = 1'b0; stg_en = 1'b1; stg_dv = 1'b0; stg_av = 1'b0;
        step();
        stg_rst = 1'b1;
        step();
        v = 16'($urandom_range(16'hFFFF, 1));
        stg_dv = 1'b1; stg_ds = v;
        step();
        stg_dv = 1'b0;
        tickc = now_cyc + (RD - 1) - (now_cyc % RD);
        for (int i = 0; i < RD + 4; i++) begin
            stg_en = (now_cyc + 1 <= tickc);
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL endrop_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
            if (dac_strobe && strobe_c < 0) begin strobe_c = now_cyc; sv = dac_sample; end
        end
        total++;
        if (strobe_c != tickc + 2 || sv !== v || dac_sample !== v) begin
            bad++; $display("FAIL endrop_complete got=%0d/%h want=%0d/%h", strobe_c, sv, tickc + 2, v);
        end
    endtask

    task automatic test_reset_mid();
        int tickc, first_u = -1;
        stg_rst = 1'b0; stg_en = 1'b1; stg_dv = 1'b0; stg_av = 1'b0;
        step();
        stg_rst = 1'b1;
        step();
        stg_dv = 1'b1; stg_ds = 16'($urandom_range(16'hFFFF, 1));
        step();
        stg_dv = 1'b0;
        tickc = now_cyc + (RD - 1) - (now_cyc % RD);
        for (int i = 0; i < 2 * RD && now_cyc < tickc + 1; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL mid_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
        end
        total++;
        if (q_dequeue !== 1'b1) begin bad++; $display("FAIL mid_in_deq got=%b want=1", q_dequeue); end
        reset_n = 1'b0;
        #1;
        total++;
        if (obs() !== 46'h0) begin bad++; $display("FAIL mid_reset_outputs got=%h want=0", obs()); end
        model_reset();
        stg_rst = 1'b0;
        step();
        stg_rst = 1'b1;
        for (int i = 0; i < RD + 2; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL mid_after cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
            if (underrun && first_u < 0) first_u = now_cyc;
        end
        total++;
        if (first_u != RD) begin bad++; $display("FAIL mid_first_tick got=%0d want=%0d", first_u, RD); end
    endtask

    task automatic test_saturation();
        stg_rst = 1'b0; stg_en = 1'b1; stg_dv = 1'b0; stg_av = 1'b0;
        step();
        stg_rst = 1'b1;
        for (int i = 0; i < 301 * RD; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL sat_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
        end
        total++;
        if (underrun_count !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d want=255", underrun_count); end
    endtask

    task automatic test_random();
        stg_rst = 1'b0; stg_en = 1'b1;
        step();
        stg_rst = 1'b1;
        for (int i = 0; i < 500; i++) begin
            stg_en = ($urandom_range(15, 0) != 0);
            stg_dv = 1'($urandom_range(1, 0));
            stg_av = 1'($urandom_range(1, 0));
            stg_ds = 16'($urandom); stg_as = 16'($urandom);
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL random_cycle cyc=%0d got=%h want=%h", now_cyc, obs(), exp_vec); end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; dsp_valid = 1'b0; aux_valid = 1'b0;
        dsp_sample = 16'h0; aux_sample = 16'h0;
        model_reset();
        now_cyc = -1;
        exp_vec = 46'h0;
        test_reset();
        test_underrun();
        test_single_push();
        test_round_robin();
        test_full();
        test_enable_drop();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
